// File: rtl/gearbox_pkg.sv
// Shared constants for the gearbox output checker: pixel pattern, phase sizing, FSM encoding.
package gearbox_pkg;

  localparam int unsigned PIX_W      = 24;
  localparam int unsigned PIX_PHASES = 4;
  localparam int unsigned PH_W       = 2;
  localparam int unsigned CNT_W      = 32;
  localparam int unsigned ERR_W      = 16;

  localparam logic [PIX_W-1:0] PIX_A = 24'hA2A1A0;
  localparam logic [PIX_W-1:0] PIX_B = 24'hB2B1B0;
  localparam logic [PIX_W-1:0] PIX_C = 24'hC2C1C0;
  localparam logic [PIX_W-1:0] PIX_D = 24'hD2D1D0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } chk_state_e;

  // Expected pixel for a given pattern phase.
  function automatic logic [PIX_W-1:0] pat_pix(input logic [PH_W-1:0] ph);
    pat_pix = PIX_A;
    case (ph)
      2'd1:    pat_pix = PIX_B;
      2'd2:    pat_pix = PIX_C;
      2'd3:    pat_pix = PIX_D;
      default: pat_pix = PIX_A;
    endcase
  endfunction

endpackage

// File: rtl/gearbox_data_chk_if.sv
// Pixel stream leaving the 32->24 gearbox: valid, end-of-frame and one RGB pixel.
interface gearbox_data_chk_if;
  import gearbox_pkg::*;

  logic             data_out_en;
  logic             data_out_last;
  logic [PIX_W-1:0] data_out_rgb;

  modport master (output data_out_en, output data_out_last, output data_out_rgb);
  modport slave  (input  data_out_en, input  data_out_last, input  data_out_rgb);
endinterface

// File: rtl/gearbox_pix_pattern.sv
// Pattern phase tracker: expected pixel for the current phase and which phase (if any) a pixel matches.
module gearbox_pix_pattern
  import gearbox_pkg::*;
#(
  parameter bit RESYNC = 1'b1
) (
  input  logic             clk_200m,
  input  logic             reset,
  input  logic             clr,
  input  logic             adv,
  input  logic             mismatch,
  input  logic [PIX_W-1:0] data,
  output logic [PIX_W-1:0] exp_pix,
  output logic [PH_W-1:0]  hit_k,
  output logic             hit_vld
);

  logic [PH_W-1:0] phase_q, phase_d;

  assign exp_pix = pat_pix(phase_q);

  // Pattern words are distinct, so at most one phase can hit.
  always_comb begin
    hit_k   = '0;
    hit_vld = 1'b0;
    for (int unsigned k = 0; k < PIX_PHASES; k++) begin
      if (data == pat_pix(PH_W'(k))) begin
        hit_k   = PH_W'(k);
        hit_vld = 1'b1;
      end
    end
  end

  always_comb begin
    phase_d = phase_q;
    if (adv) begin
      if (RESYNC && mismatch && hit_vld) phase_d = hit_k + PH_W'(1);
      else                                phase_d = phase_q + PH_W'(1);
    end
  end

  always_ff @(posedge clk_200m) begin
    if (!reset || clr) phase_q <= '0;
    else               phase_q <= phase_d;
  end

endmodule

// File: rtl/gearbox_data_chk.sv
// Checker at the 24-bit gearbox output: pattern compare, pixel/error counts, protocol and stall watchdog,
// registered pass/fail verdict.
module gearbox_data_chk
  import gearbox_pkg::*;
#(
  parameter logic [31:0] EXP_PIXELS  = 32'd0,
  parameter logic [31:0] TIMEOUT_CYC = 32'd4096,
  parameter bit          RESYNC      = 1'b1
) (
  input  logic              clk_200m,
  input  logic              reset,
  input  logic              chk_clr,
  gearbox_data_chk_if.slave pix,
  output logic              chk_done,
  output logic              chk_pass,
  output logic [CNT_W-1:0]  pix_cnt,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  first_err_idx,
  output logic [PIX_W-1:0]  first_err_data,
  output logic              proto_err,
  output logic              timeout_err
);

  chk_state_e       state_q, state_d;
  logic [CNT_W-1:0] pix_q, pix_d, fidx_q, fidx_d, idle_q, idle_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [PIX_W-1:0] fdata_q, fdata_d, exp_pix;
  logic             proto_q, proto_d, tmo_q, tmo_d, done_q, done_d, pass_q, pass_d;
  logic [PH_W-1:0]  hit_k;
  logic             hit_vld, accept, mismatch, tmo_hit;

  assign accept   = pix.data_out_en && (state_q != ST_DONE);
  assign mismatch = accept && (pix.data_out_rgb != exp_pix);
  // A valid pixel on the expiry cycle keeps the frame alive.
  assign tmo_hit  = (state_q == ST_RUN) && !pix.data_out_en && (TIMEOUT_CYC != 32'd0) &&
                    (idle_q == TIMEOUT_CYC - 32'd1);

  gearbox_pix_pattern #(.RESYNC(RESYNC)) u_pattern (
    .clk_200m (clk_200m),
    .reset    (reset),
    .clr      (chk_clr),
    .adv      (accept),
    .mismatch (mismatch),
    .data     (pix.data_out_rgb),
    .exp_pix  (exp_pix),
    .hit_k    (hit_k),
    .hit_vld  (hit_vld)
  );

  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    err_d   = err_q;
    fidx_d  = fidx_q;
    fdata_d = fdata_q;
    proto_d = proto_q;
    tmo_d   = tmo_q;
    idle_d  = idle_q;

    case (state_q)
      ST_IDLE: if (accept) state_d = pix.data_out_last ? ST_DONE : ST_RUN;
      ST_RUN: begin
        if (accept && pix.data_out_last) begin
          state_d = ST_DONE;
        end else if (tmo_hit) begin
          state_d = ST_DONE;
          tmo_d   = 1'b1;
        end
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      pix_d = pix_q + CNT_W'(1);
      if (mismatch) begin
        if (err_q == '0) begin
          fidx_d  = pix_q;
          fdata_d = pix.data_out_rgb;
        end
        if (err_q != '1) err_d = err_q + ERR_W'(1);
      end
    end

    if ((pix.data_out_last && !pix.data_out_en) || (pix.data_out_en && state_q == ST_DONE))
      proto_d = 1'b1;

    if (pix.data_out_en)                        idle_d = '0;
    else if (state_q == ST_RUN && idle_q != '1) idle_d = idle_q + CNT_W'(1);

    done_d = (state_d == ST_DONE);
    pass_d = done_d && (err_d == '0) && !proto_d && !tmo_d &&
             ((EXP_PIXELS == 32'd0) || (pix_d == EXP_PIXELS));
  end

  always_ff @(posedge clk_200m) begin
    if (!reset || chk_clr) begin
      state_q <= ST_IDLE;
      pix_q   <= '0;
      err_q   <= '0;
      fidx_q  <= '0;
      fdata_q <= '0;
      proto_q <= 1'b0;
      tmo_q   <= 1'b0;
      idle_q  <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      err_q   <= err_d;
      fidx_q  <= fidx_d;
      fdata_q <= fdata_d;
      proto_q <= proto_d;
      tmo_q   <= tmo_d;
      idle_q  <= idle_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign chk_done       = done_q;
  assign chk_pass       = pass_q;
  assign pix_cnt        = pix_q;
  assign err_cnt        = err_q;
  assign first_err_idx  = fidx_q;
  assign first_err_data = fdata_q;
  assign proto_err      = proto_q;
  assign timeout_err    = tmo_q;

endmodule

// File: tb/tb_gearbox_data_chk.sv
// Bench for gearbox_data_chk: three checker instances (resync on, resync off, fixed length 40) share one stream.
module tb_gearbox_data_chk;

  localparam int unsigned TO      = 16;
  localparam int unsigned EXP_LEN = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        clr;
  gearbox_data_chk_if bus();

  logic        done_o  [3];
  logic        pass_o  [3];
  logic [31:0] pixc    [3];
  logic [15:0] errc    [3];
  logic [31:0] fidx_o  [3];
  logic [23:0] fdata_o [3];
  logic        proto_o [3];
  logic        tmo_o   [3];

  gearbox_data_chk #(.EXP_PIXELS(32'd0), .TIMEOUT_CYC(32'(TO)), .RESYNC(1'b1)) u_r1 (
    .clk_200m(clk), .reset(rst_n), .chk_clr(clr), .pix(bus),
    .chk_done(done_o[0]), .chk_pass(pass_o[0]), .pix_cnt(pixc[0]), .err_cnt(errc[0]),
    .first_err_idx(fidx_o[0]), .first_err_data(fdata_o[0]), .proto_err(proto_o[0]), .timeout_err(tmo_o[0]));

  gearbox_data_chk #(.EXP_PIXELS(32'd0), .TIMEOUT_CYC(32'(TO)), .RESYNC(1'b0)) u_r0 (
    .clk_200m(clk), .reset(rst_n), .chk_clr(clr), .pix(bus),
    .chk_done(done_o[1]), .chk_pass(pass_o[1]), .pix_cnt(pixc[1]), .err_cnt(errc[1]),
    .first_err_idx(fidx_o[1]), .first_err_data(fdata_o[1]), .proto_err(proto_o[1]), .timeout_err(tmo_o[1]));

  gearbox_data_chk #(.EXP_PIXELS(32'(EXP_LEN)), .TIMEOUT_CYC(32'(TO)), .RESYNC(1'b1)) u_len (
    .clk_200m(clk), .reset(rst_n), .chk_clr(clr), .pix(bus),
    .chk_done(done_o[2]), .chk_pass(pass_o[2]), .pix_cnt(pixc[2]), .err_cnt(errc[2]),
    .first_err_idx(fidx_o[2]), .first_err_data(fdata_o[2]), .proto_err(proto_o[2]), .timeout_err(tmo_o[2]));

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  logic [23:0] PAT [4];

  // Frame-level reference state, one set per instance.
  int unsigned m_st   [3];   // 0 waiting, 1 in frame, 2 finished
  int unsigned m_ph   [3];
  int unsigned m_idle [3];
  int unsigned m_err  [3];
  logic [31:0] m_pix  [3];
  logic [31:0] m_fidx [3];
  logic [23:0] m_fdata[3];
  bit          m_proto[3];
  bit          m_tmo  [3];

  typedef struct {
    bit          en;
    bit          last;
    bit          c;
    bit          r;
    logic [23:0] rgb;
    logic [31:0] e_pix;
    logic [15:0] e_err;
    bit          e_done;
    bit          e_proto;
  } vec_t;
  vec_t tbl [$];

  function automatic logic [23:0] pat(input int unsigned i);
    return PAT[i % 4];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit en, input bit last, input logic [23:0] rgb, input bit c, input bit r);
    for (int m = 0; m < 3; m++) begin
      int unsigned ost;
      bit          acc;
      int          k;
      if (!r || c) begin
        m_st[m] = 0; m_ph[m] = 0; m_idle[m] = 0; m_err[m] = 0; m_pix[m] = '0;
        m_fidx[m] = '0; m_fdata[m] = '0; m_proto[m] = 1'b0; m_tmo[m] = 1'b0;
      end else begin
        ost = m_st[m];
        acc = en && (ost != 2);
        if ((en && ost == 2) || (last && !en)) m_proto[m] = 1'b1;
        if (acc) begin
          if (rgb == PAT[m_ph[m]]) begin
            m_ph[m] = (m_ph[m] + 1) % 4;
          end else begin
            if (m_err[m] == 0) begin
              m_fidx[m]  = m_pix[m];
              m_fdata[m] = rgb;
            end
            if (m_err[m] < 65535) m_err[m]++;
            k = -1;
            if (m != 1) for (int j = 0; j < 4; j++) if (rgb == PAT[j]) k = j;
            m_ph[m] = (k >= 0) ? (k + 1) % 4 : (m_ph[m] + 1) % 4;
          end
          m_pix[m] = m_pix[m] + 32'd1;
          if (last)          m_st[m] = 2;
          else if (ost == 0) m_st[m] = 1;
        end else if (ost == 1 && m_idle[m] == TO - 1) begin
          m_st[m]  = 2;
          m_tmo[m] = 1'b1;
        end
        if (en)            m_idle[m] = 0;
        else if (ost == 1) m_idle[m]++;
      end
    end
  endtask

  task automatic check_all();
    for (int m = 0; m < 3; m++) begin
      bit pass_e;
      pass_e = (m_st[m] == 2) && (m_err[m] == 0) && !m_proto[m] && !m_tmo[m] &&
               ((m != 2) || (m_pix[m] == 32'(EXP_LEN)));
      chk($sformatf("u%0d.done", m),  32'(done_o[m]),  32'(m_st[m] == 2));
      chk($sformatf("u%0d.pass", m),  32'(pass_o[m]),  32'(pass_e));
      chk($sformatf("u%0d.pix", m),   pixc[m],         m_pix[m]);
      chk($sformatf("u%0d.err", m),   32'(errc[m]),    m_err[m]);
      chk($sformatf("u%0d.fidx", m),  fidx_o[m],       m_fidx[m]);
      chk($sformatf("u%0d.fdata", m), 32'(fdata_o[m]), 32'(m_fdata[m]));
      chk($sformatf("u%0d.proto", m), 32'(proto_o[m]), 32'(m_proto[m]));
      chk($sformatf("u%0d.tmo", m),   32'(tmo_o[m]),   32'(m_tmo[m]));
    end
  endtask

  task automatic tick(input bit en, input bit last, input logic [23:0] rgb, input bit c, input bit r);
    bus.data_out_en   = en;
    bus.data_out_last = last;
    bus.data_out_rgb  = rgb;
    clr               = c;
    rst_n             = r;
    @(posedge clk);
    model_step(en, last, rgb, c, r);
    @(negedge clk);
    check_all();
  endtask

  task automatic px(input logic [23:0] rgb, input bit last);
    tick(1'b1, last, rgb, 1'b0, 1'b1);
  endtask

  task automatic idle_cyc();
    tick(1'b0, 1'b0, 24'h0, 1'b0, 1'b1);
  endtask

  task automatic do_clr();
    tick(1'b0, 1'b0, 24'h0, 1'b1, 1'b1);
  endtask

  initial begin
    int unsigned seq;
    PAT[0] = 24'hA2A1A0; PAT[1] = 24'hB2B1B0; PAT[2] = 24'hC2C1C0; PAT[3] = 24'hD2D1D0;
    for (int m = 0; m < 3; m++) begin
      m_st[m] = 0; m_ph[m] = 0; m_idle[m] = 0; m_err[m] = 0; m_pix[m] = '0;
      m_fidx[m] = '0; m_fdata[m] = '0; m_proto[m] = 1'b0; m_tmo[m] = 1'b0;
    end

    //               en    last  clr   rst   rgb          pix    err    done  proto
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 24'hA2A1A0, 32'd0, 16'd0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 24'hA2A1A0, 32'd1, 16'd0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 24'hB2B1B0, 32'd2, 16'd0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 24'h000000, 32'd3, 16'd1, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 24'hD2D1D0, 32'd4, 16'd1, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 24'hA2A1A0, 32'd5, 16'd1, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 24'hB2B1B0, 32'd5, 16'd1, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 24'h000000, 32'd0, 16'd0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 24'h000000, 32'd0, 16'd0, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 24'hA2A1A0, 32'd0, 16'd0, 1'b0, 1'b0});

    for (int i = 0; i < tbl.size(); i++) begin
      tick(tbl[i].en, tbl[i].last, tbl[i].rgb, tbl[i].c, tbl[i].r);
      chk($sformatf("tbl%0d.pix", i),   pixc[0],            tbl[i].e_pix);
      chk($sformatf("tbl%0d.err", i),   32'(errc[0]),       32'(tbl[i].e_err));
      chk($sformatf("tbl%0d.done", i),  32'(done_o[0]),     32'(tbl[i].e_done));
      chk($sformatf("tbl%0d.proto", i), 32'(proto_o[0]),    32'(tbl[i].e_proto));
    end
    chk("tbl.fidx", fidx_o[0], 32'd0);

    // Long continuous frame.
    do_clr();
    for (int i = 0; i < 4000; i++) px(pat(i), i == 3999);
    chk("t1.pix",  pixc[0],         32'd4000);
    chk("t1.done", 32'(done_o[0]),  32'd1);
    chk("t1.pass", 32'(pass_o[0]),  32'd1);
    chk("t1.err",  32'(errc[0]),    32'd0);
    chk("t1.len_pass", 32'(pass_o[2]), 32'd0);

    // Gated 2 on / 2 off, exact expected length.
    do_clr();
    for (int i = 0; i < 40; i++) begin
      px(pat(i), i == 39);
      if (i % 2 == 1 && i != 39) begin idle_cyc(); idle_cyc(); end
    end
    chk("t2.len_pass", 32'(pass_o[2]), 32'd1);
    chk("t2.len_pix",  pixc[2],        32'd40);
    chk("t2.tmo",      32'(tmo_o[2]),  32'd0);

    // Single corrupted pixel.
    do_clr();
    for (int i = 0; i < 16; i++) px((i == 10) ? 24'h000000 : pat(i), i == 15);
    chk("t3.err",   32'(errc[0]),    32'd1);
    chk("t3.fidx",  fidx_o[0],       32'd10);
    chk("t3.fdata", 32'(fdata_o[0]), 32'd0);
    chk("t3.pass",  32'(pass_o[0]),  32'd0);
    chk("t3.done",  32'(done_o[0]),  32'd1);

    // Dropped pixel #5.
    do_clr();
    for (int j = 0; j <= 20; j++) if (j != 5) px(pat(j), j == 20);
    chk("t4.r1_err",   32'(errc[0]),    32'd1);
    chk("t4.r1_fidx",  fidx_o[0],       32'd5);
    chk("t4.r1_fdata", 32'(fdata_o[0]), 32'hC2C1C0);
    chk("t4.r0_err",   32'(errc[1]),    32'd15);

    // Stall watchdog.
    do_clr();
    for (int i = 0; i < 6; i++) px(pat(i), 1'b0);
    for (int i = 0; i < 15; i++) idle_cyc();
    chk("t5.done_early", 32'(done_o[0]), 32'd0);
    idle_cyc();
    chk("t5.done", 32'(done_o[0]), 32'd1);
    chk("t5.tmo",  32'(tmo_o[0]),  32'd1);
    chk("t5.pass", 32'(pass_o[0]), 32'd0);
    chk("t5.pix",  pixc[0],        32'd6);

    // Protocol faults, then reset mid-frame and a clean frame.
    do_clr();
    for (int i = 0; i < 3; i++) px(pat(i), 1'b0);
    tick(1'b0, 1'b1, 24'h0, 1'b0, 1'b1);
    chk("t6.proto", 32'(proto_o[0]), 32'd1);
    chk("t6.nodone", 32'(done_o[0]), 32'd0);
    px(pat(3), 1'b1);
    px(pat(4), 1'b0);
    chk("t6.pix_frozen", pixc[0], 32'd4);
    chk("t6.pass", 32'(pass_o[0]), 32'd0);
    do_clr();
    for (int i = 0; i < 3; i++) px(pat(i), 1'b0);
    tick(1'b1, 1'b0, pat(3), 1'b0, 1'b0);
    chk("t6.rst_pix",  pixc[0],       32'd0);
    chk("t6.rst_done", 32'(done_o[0]), 32'd0);
    for (int i = 0; i < 8; i++) px(pat(i), i == 7);
    chk("t6.clean_pass", 32'(pass_o[0]), 32'd1);

    // Randomized traffic against the reference model.
    do_clr();
    seq = 0;
    for (int n = 0; n < 3000; n++) begin
      if (m_st[0] == 2 && $urandom_range(0, 3) == 0) begin
        do_clr();
        seq = 0;
      end else if ($urandom_range(0, 499) == 0) begin
        tick(1'b1, 1'b0, pat(seq), 1'b0, 1'b0);
        seq = 0;
      end else if ($urandom_range(0, 199) == 0) begin
        for (int g = 0; g < 20; g++) idle_cyc();
      end else if ($urandom_range(0, 3) != 0) begin
        logic [23:0] rgb;
        rgb = ($urandom_range(0, 19) == 0) ? 24'($urandom) : pat(seq);
        seq = seq + (($urandom_range(0, 29) == 0) ? 2 : 1);
        px(rgb, $urandom_range(0, 60) == 0);
      end else begin
        tick(1'b0, $urandom_range(0, 40) == 0, 24'($urandom), 1'b0, 1'b1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
